// File: rtl/ram_arbiter.sv
// Shares one synchronous single-port 32-bit RAM between the CPU bus and a DMA master.
// Each access runs IDLE -> ISSUE -> CAPT with all RAM control registered.
module ram_arbiter #(
  parameter int AW       = 10,
  parameter bit CPU_PRIO = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_ack,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [31:0]   dma_wdata,
  output logic [31:0]   dma_rdata,
  output logic          dma_ack,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [31:0]   ram_din,
  input  logic [31:0]   ram_dout,
  output logic          busy,
  output logic          gnt,
  output logic [15:0]   conflict_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2
  } state_t;

  state_t        state_q;
  logic [AW-1:0] ram_addr_q;
  logic          ram_we_q;
  logic [31:0]   ram_din_q;
  logic [31:0]   cpu_rdata_q;
  logic [31:0]   dma_rdata_q;
  logic          cpu_ack_q;
  logic          dma_ack_q;
  logic          gnt_q;
  logic          rr_q;
  logic [15:0]   cnt_q;

  logic          mreq_cpu;
  logic          mreq_dma;
  logic          tie;
  logic          win_dma_d;
  logic [AW-1:0] addr_d;
  logic          we_d;
  logic [31:0]   din_d;
  logic [15:0]   cnt_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A port whose ack is visible this cycle is masked so a registered requester
  // can drop req one edge late without being granted a second time.
  always_comb begin
    mreq_cpu  = cpu_req & ~cpu_ack_q;
    mreq_dma  = dma_req & ~dma_ack_q;
    tie       = mreq_cpu & mreq_dma;
    win_dma_d = mreq_dma;
    if (tie) begin
      win_dma_d = CPU_PRIO ? 1'b0 : rr_q;
    end
    addr_d = win_dma_d ? dma_addr  : cpu_addr;
    we_d   = win_dma_d ? dma_we    : cpu_we;
    din_d  = win_dma_d ? dma_wdata : cpu_wdata;
    cnt_d  = tie ? sat_inc16(cnt_q) : cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_din_q   <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      gnt_q       <= 1'b0;
      rr_q        <= 1'b0;
      cnt_q       <= '0;
    end else begin
      cpu_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= cnt_d;
          if (mreq_cpu | mreq_dma) begin
            ram_addr_q <= addr_d;
            ram_we_q   <= we_d;
            ram_din_q  <= din_d;
            gnt_q      <= win_dma_d;
            rr_q       <= ~win_dma_d;
            state_q    <= ISSUE;
          end else begin
            ram_we_q <= 1'b0;
          end
        end
        ISSUE: begin
          ram_we_q <= 1'b0;
          state_q  <= CAPT;
        end
        CAPT: begin
          // Writes also capture ram_dout, returning the RAM's read-during-write data.
          if (gnt_q) begin
            dma_rdata_q <= ram_dout;
            dma_ack_q   <= 1'b1;
          end else begin
            cpu_rdata_q <= ram_dout;
            cpu_ack_q   <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: begin
          ram_we_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign ram_addr     = ram_addr_q;
  assign ram_we       = ram_we_q;
  assign ram_din      = ram_din_q;
  assign cpu_rdata    = cpu_rdata_q;
  assign dma_rdata    = dma_rdata_q;
  assign cpu_ack      = cpu_ack_q;
  assign dma_ack      = dma_ack_q;
  assign gnt          = gnt_q;
  assign busy         = (state_q != IDLE);
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a round-robin instance and a CPU-priority instance, each
// with its own read-first synchronous RAM model, plus a transaction-level reference.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [9:0]  cpu_addr, dma_addr, ram_addr;
  logic [31:0] cpu_wdata, dma_wdata, cpu_rdata, dma_rdata, ram_din, ram_dout;
  logic        cpu_ack, dma_ack, ram_we, busy, gnt;
  logic [15:0] conflict_cnt;
  logic        f_cpu_req, f_cpu_we, f_dma_req, f_dma_we;
  logic [9:0]  f_cpu_addr, f_dma_addr, f_ram_addr;
  logic [31:0] f_cpu_wdata, f_dma_wdata, f_cpu_rdata, f_dma_rdata, f_ram_din, f_ram_dout;
  logic        f_cpu_ack, f_dma_ack, f_ram_we, f_busy, f_gnt;
  logic [15:0] f_conflict_cnt;

  logic        pre_we = 1'b0;
  logic [9:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  logic [31:0] mem  [1024];
  logic [31:0] fmem [1024];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.AW(10), .CPU_PRIO(1'b0)) u_rr (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .busy(busy), .gnt(gnt), .conflict_cnt(conflict_cnt)
  );

  ram_arbiter #(.AW(10), .CPU_PRIO(1'b1)) u_fp (
    .clk(clk), .rst(rst),
    .cpu_req(f_cpu_req), .cpu_we(f_cpu_we), .cpu_addr(f_cpu_addr), .cpu_wdata(f_cpu_wdata),
    .cpu_rdata(f_cpu_rdata), .cpu_ack(f_cpu_ack),
    .dma_req(f_dma_req), .dma_we(f_dma_we), .dma_addr(f_dma_addr), .dma_wdata(f_dma_wdata),
    .dma_rdata(f_dma_rdata), .dma_ack(f_dma_ack),
    .ram_addr(f_ram_addr), .ram_we(f_ram_we), .ram_din(f_ram_din), .ram_dout(f_ram_dout),
    .busy(f_busy), .gnt(f_gnt), .conflict_cnt(f_conflict_cnt)
  );

  // Read-first synchronous RAMs; the preload port writes both while the arbiters are idle.
  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_addr]  <= pre_data;
      fmem[pre_addr] <= pre_data;
    end else begin
      if (ram_we)   mem[ram_addr]    <= ram_din;
      if (f_ram_we) fmem[f_ram_addr] <= f_ram_din;
    end
    ram_dout   <= mem[ram_addr];
    f_ram_dout <= fmem[f_ram_addr];
  end

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cpu_req = 1'b0; dma_req = 1'b0; f_cpu_req = 1'b0; f_dma_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (ram_addr !== 10'd0) begin n_err++; $display("FAIL reset_ram_addr: got %h expected 0", ram_addr); end
    n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL reset_ram_we: got %b expected 0", ram_we); end
    n_cmp++; if (ram_din !== 32'd0) begin n_err++; $display("FAIL reset_ram_din: got %h expected 0", ram_din); end
    n_cmp++; if (cpu_rdata !== 32'd0) begin n_err++; $display("FAIL reset_cpu_rdata: got %h expected 0", cpu_rdata); end
    n_cmp++; if (dma_rdata !== 32'd0) begin n_err++; $display("FAIL reset_dma_rdata: got %h expected 0", dma_rdata); end
    n_cmp++; if ({cpu_ack, dma_ack} !== 2'b00) begin n_err++; $display("FAIL reset_acks: got %b expected 00", {cpu_ack, dma_ack}); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (gnt !== 1'b0) begin n_err++; $display("FAIL reset_gnt: got %b expected 0", gnt); end
    n_cmp++; if (conflict_cnt !== 16'd0) begin n_err++; $display("FAIL reset_conflict_cnt: got %h expected 0", conflict_cnt); end
    n_cmp++;
    if ({f_ram_addr, f_ram_we, f_ram_din, f_cpu_rdata, f_dma_rdata, f_cpu_ack, f_dma_ack, f_busy, f_gnt, f_conflict_cnt} !== '0) begin
      n_err++; $display("FAIL reset_fp_outputs: got nonzero addr=%h we=%b busy=%b gnt=%b cnt=%h expected all 0",
                        f_ram_addr, f_ram_we, f_busy, f_gnt, f_conflict_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if ({busy, cpu_ack, dma_ack, ram_we} !== 4'b0000) begin n_err++; $display("FAIL reset_idle_after_release: got %b expected 0000", {busy, cpu_ack, dma_ack, ram_we}); end
  endtask

  task automatic test_cpu_read();
    preload(10'd5, 32'hDEADBEEF);
    preload(10'd3, 32'hA5A50003);
    preload(10'd7, 32'h0BADF00D);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'd5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (cpu_ack !== (i == 2)) begin n_err++; $display("FAIL cpu_read_ack[%0d]: got %b expected %b", i, cpu_ack, (i == 2)); end
      n_cmp++; if (busy !== (i < 2)) begin n_err++; $display("FAIL cpu_read_busy[%0d]: got %b expected %b", i, busy, (i < 2)); end
      if (i == 0) begin
        n_cmp++; if (ram_addr !== 10'd5) begin n_err++; $display("FAIL cpu_read_ram_addr: got %h expected 005", ram_addr); end
      end
      if (i >= 2) begin
        n_cmp++; if (cpu_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL cpu_read_rdata[%0d]: got %h expected deadbeef", i, cpu_rdata); end
      end
      if (i == 2) cpu_req = 1'b0;
    end
  endtask

  task automatic test_dma_write_cpu_read();
    int we_cnt, ack_cnt;
    logic [31:0] got;
    we_cnt = 0; ack_cnt = 0; got = '0;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 10'd3; dma_wdata = 32'h12345678;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (ram_we === 1'b1) we_cnt++;
      if (dma_ack === 1'b1) begin ack_cnt++; got = dma_rdata; dma_req = 1'b0; end
    end
    n_cmp++; if (we_cnt != 1) begin n_err++; $display("FAIL dma_write_we_cycles: got %0d expected 1", we_cnt); end
    n_cmp++; if (ack_cnt != 1) begin n_err++; $display("FAIL dma_write_ack_count: got %0d expected 1", ack_cnt); end
    n_cmp++; if (got !== 32'hA5A50003) begin n_err++; $display("FAIL dma_write_rdw_data: got %h expected a5a50003", got); end
    ack_cnt = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'd3;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (cpu_ack === 1'b1) begin ack_cnt++; got = cpu_rdata; cpu_req = 1'b0; end
    end
    n_cmp++; if (ack_cnt != 1) begin n_err++; $display("FAIL cpu_after_dma_ack_count: got %0d expected 1", ack_cnt); end
    n_cmp++; if (got !== 32'h12345678) begin n_err++; $display("FAIL cpu_after_dma_rdata: got %h expected 12345678", got); end
  endtask

  task automatic test_contention();
    bit ec, ed;
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'd5;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 10'd3;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      ec = (i % 3 == 2) && ((i / 3) % 2 == 0);
      ed = (i % 3 == 2) && ((i / 3) % 2 == 1);
      n_cmp++; if ({cpu_ack, dma_ack} !== {ec, ed}) begin n_err++; $display("FAIL contention_acks[%0d]: got %b expected %b", i, {cpu_ack, dma_ack}, {ec, ed}); end
      if (ec) begin n_cmp++; if (cpu_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL contention_cpu_rdata: got %h expected deadbeef", cpu_rdata); end end
      if (ed) begin n_cmp++; if (dma_rdata !== 32'h12345678) begin n_err++; $display("FAIL contention_dma_rdata: got %h expected 12345678", dma_rdata); end end
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (conflict_cnt !== 16'd1) begin n_err++; $display("FAIL contention_conflict_cnt: got %0d expected 1", conflict_cnt); end
  endtask

  task automatic test_fixed_priority();
    bit fc, fd, rc, rd;
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'd5;
    f_cpu_req = 1'b1; f_cpu_we = 1'b0; f_cpu_addr = 10'd5;
    repeat (3) @(negedge clk);
    n_cmp++; if ({f_cpu_ack, cpu_ack} !== 2'b11) begin n_err++; $display("FAIL prio_solo_ack: got %b expected 11", {f_cpu_ack, cpu_ack}); end
    cpu_req = 1'b0; f_cpu_req = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 10'd3;
    f_cpu_req = 1'b1; f_dma_req = 1'b1; f_dma_we = 1'b0; f_dma_addr = 10'd3;
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      fc = (j == 2) || (j == 8); fd = (j == 5);
      rd = (j == 2) || (j == 8); rc = (j == 5);
      n_cmp++; if ({f_cpu_ack, f_dma_ack} !== {fc, fd}) begin n_err++; $display("FAIL prio_fp_acks[%0d]: got %b expected %b", j, {f_cpu_ack, f_dma_ack}, {fc, fd}); end
      n_cmp++; if ({cpu_ack, dma_ack} !== {rc, rd}) begin n_err++; $display("FAIL prio_rr_acks[%0d]: got %b expected %b", j, {cpu_ack, dma_ack}, {rc, rd}); end
      if (fc) begin n_cmp++; if (f_cpu_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL prio_fp_cpu_rdata: got %h expected deadbeef", f_cpu_rdata); end end
      if (fd) begin n_cmp++; if (f_dma_rdata !== 32'hA5A50003) begin n_err++; $display("FAIL prio_fp_dma_rdata: got %h expected a5a50003", f_dma_rdata); end end
    end
    cpu_req = 1'b0; dma_req = 1'b0; f_cpu_req = 1'b0; f_dma_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (f_conflict_cnt !== 16'd1) begin n_err++; $display("FAIL prio_fp_conflict_cnt: got %0d expected 1", f_conflict_cnt); end
    n_cmp++; if (conflict_cnt !== 16'd1) begin n_err++; $display("FAIL prio_rr_conflict_cnt: got %0d expected 1", conflict_cnt); end
  endtask

  task automatic test_ack_mask();
    int acks, busy_cnt;
    bit drop_next;
    acks = 0; busy_cnt = 0; drop_next = 1'b0;
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'd5;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (drop_next) begin cpu_req = 1'b0; drop_next = 1'b0; end
      if (cpu_ack === 1'b1) begin acks++; drop_next = 1'b1; end
    end
    n_cmp++; if (acks != 1) begin n_err++; $display("FAIL ack_mask_ack_count: got %0d expected 1", acks); end
    n_cmp++; if (busy_cnt != 2) begin n_err++; $display("FAIL ack_mask_busy_cycles: got %0d expected 2", busy_cnt); end
  endtask

  task automatic test_async_reset();
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'd7; cpu_wdata = 32'hCAFE0007;
    @(negedge clk);
    n_cmp++; if ({ram_we, busy} !== 2'b11) begin n_err++; $display("FAIL areset_issue_state: got %b expected 11", {ram_we, busy}); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({ram_we, busy, gnt} !== 3'b000) begin n_err++; $display("FAIL areset_immediate: got %b expected 000", {ram_we, busy, gnt}); end
    n_cmp++; if ({ram_addr, ram_din} !== '0) begin n_err++; $display("FAIL areset_ram_bus: got addr=%h din=%h expected 0", ram_addr, ram_din); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (cpu_ack !== 1'b0) begin n_err++; $display("FAIL areset_no_ack[%0d]: got %b expected 0", i, cpu_ack); end
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (cpu_ack !== (i == 2)) begin n_err++; $display("FAIL areset_resume_ack[%0d]: got %b expected %b", i, cpu_ack, (i == 2)); end
      if (i == 2) begin
        n_cmp++; if (cpu_rdata !== 32'h0BADF00D) begin n_err++; $display("FAIL areset_resume_rdata: got %h expected 0badf00d", cpu_rdata); end
        cpu_req = 1'b0;
      end
    end
  endtask

  // Reference: an access granted at edge g occupies the RAM until g+3, acks at g+2,
  // and the acked port is ignored at g+3; ties go to the port that lost last time.
  task automatic test_random();
    logic [31:0] mm [16];
    bit          r_req [2];
    bit          r_we [2];
    bit          hold [2];
    logic [9:0]  r_addr [2];
    logic [31:0] r_data [2];
    logic [31:0] exp_rd [2];
    int          ack_rise [2];
    int          e, free_e, we_e, conf_m;
    bit          rr_m, mc, md, w, exp_gnt;
    for (int a = 0; a < 16; a++) begin
      mm[a] = $urandom;
      preload(10'(a), mm[a]);
    end
    do_reset();
    e = 0; free_e = 0; we_e = -10; conf_m = 0; rr_m = 1'b0; exp_gnt = 1'b0;
    for (int p = 0; p < 2; p++) begin
      r_req[p] = 1'b0; r_we[p] = 1'b0; hold[p] = 1'b0; r_addr[p] = '0;
      r_data[p] = '0; exp_rd[p] = '0; ack_rise[p] = -10;
    end
    repeat (600) begin
      @(posedge clk);
      e++;
      if (e >= free_e) begin
        mc = r_req[0] && (ack_rise[0] != e - 1);
        md = r_req[1] && (ack_rise[1] != e - 1);
        if (mc || md) begin
          w = (mc && md) ? rr_m : md;
          if (mc && md && conf_m < 65535) conf_m++;
          rr_m = !w; exp_gnt = w; ack_rise[w] = e + 2; free_e = e + 3;
          exp_rd[w] = mm[r_addr[w][3:0]];
          if (r_we[w]) begin mm[r_addr[w][3:0]] = r_data[w]; we_e = e; end
        end
      end
      @(negedge clk);
      n_cmp++; if ({cpu_ack, dma_ack} !== {ack_rise[0] == e, ack_rise[1] == e}) begin
        n_err++; $display("FAIL rand_acks@%0d: got %b expected %b", e, {cpu_ack, dma_ack}, {ack_rise[0] == e, ack_rise[1] == e});
      end
      if (ack_rise[0] == e) begin n_cmp++; if (cpu_rdata !== exp_rd[0]) begin n_err++; $display("FAIL rand_cpu_rdata@%0d: got %h expected %h", e, cpu_rdata, exp_rd[0]); end end
      if (ack_rise[1] == e) begin n_cmp++; if (dma_rdata !== exp_rd[1]) begin n_err++; $display("FAIL rand_dma_rdata@%0d: got %h expected %h", e, dma_rdata, exp_rd[1]); end end
      n_cmp++; if (gnt !== exp_gnt) begin n_err++; $display("FAIL rand_gnt@%0d: got %b expected %b", e, gnt, exp_gnt); end
      n_cmp++; if (ram_we !== (we_e == e)) begin n_err++; $display("FAIL rand_ram_we@%0d: got %b expected %b", e, ram_we, (we_e == e)); end
      n_cmp++; if (busy !== (e >= free_e - 3 && e <= free_e - 2)) begin
        n_err++; $display("FAIL rand_busy@%0d: got %b expected %b", e, busy, (e >= free_e - 3 && e <= free_e - 2));
      end
      for (int p = 0; p < 2; p++) begin
        if (ack_rise[p] == e) begin
          if ($urandom_range(1, 0) == 0) r_req[p] = 1'b0;
          else hold[p] = 1'b1;
        end else if (hold[p]) begin
          r_req[p] = 1'b0; hold[p] = 1'b0;
        end else if (!r_req[p] && $urandom_range(2, 0) == 0) begin
          r_req[p] = 1'b1; r_we[p] = 1'($urandom_range(1, 0));
          r_addr[p] = 10'($urandom_range(15, 0)); r_data[p] = $urandom;
        end
      end
      cpu_req = r_req[0]; cpu_we = r_we[0]; cpu_addr = r_addr[0]; cpu_wdata = r_data[0];
      dma_req = r_req[1]; dma_we = r_we[1]; dma_addr = r_addr[1]; dma_wdata = r_data[1];
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if (conflict_cnt !== 16'(conf_m)) begin n_err++; $display("FAIL rand_conflict_cnt: got %0d expected %0d", conflict_cnt, conf_m); end
  endtask

  initial begin
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    f_cpu_req = 1'b0; f_cpu_we = 1'b0; f_cpu_addr = '0; f_cpu_wdata = '0;
    f_dma_req = 1'b0; f_dma_we = 1'b0; f_dma_addr = '0; f_dma_wdata = '0;
    test_reset();
    test_cpu_read();
    test_dma_write_cpu_read();
    test_contention();
    test_fixed_priority();
    test_ack_mask();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single-port 32-bit data RAM between the CPU-side bus (MIO_BUS RAM port) and a second master (DMA/display fetch). It sequences each access through a fixed three-phase FSM and registers all RAM control. Requests from both masters are arbitrated round-robin or fixed-priority. It returns per-port acknowledge and read data; `cpu_ack` is the CPU's memory-ready signal.

## Interface
- `AW`, 10, RAM word-address width.
- `CPU_PRIO`, 0, 0 = round-robin on ties; 1 = CPU always wins ties.
- `clk` in 1: system clock; RAM is clocked by the same clock.
- `rst` in 1: reset, asynchronous, active-high.
- `cpu_req` in 1: CPU request, held with addr/we/wdata stable until `cpu_ack`.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in AW: word address.
- `cpu_wdata` in 32: write data.
- `cpu_rdata` out 32: read data, valid while `cpu_ack`=1 and held afterwards.
- `cpu_ack` out 1: one-cycle completion pulse.
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_rdata`, `dma_ack`: same as the CPU group, for port 1.
- `ram_addr` out AW: registered RAM address.
- `ram_we` out 1: registered RAM write enable.
- `ram_din` out 32: registered RAM write data.
- `ram_dout` in 32: RAM read data, synchronous, valid one edge after address sampled.
- `busy` out 1: FSM not in IDLE.
- `gnt` out 1: port owning the current/last access (0 = CPU, 1 = DMA).
- `conflict_cnt` out 16: saturating count of IDLE cycles in which both masked requests were high.

## Operation
- States: IDLE, ISSUE, CAPT.
- Masked request: `mreq_n = n_req & ~n_ack`. This blocks re-grant of a port in the cycle its ack is visible, so a registered requester may drop `req` one edge after `ack`.
- **IDLE, no masked request**: stay in IDLE; `ram_we`=0.
- **IDLE, one masked request**: grant that port.
- **IDLE, both masked requests**:
  - CPU_PRIO=1: grant CPU.
  - CPU_PRIO=0: grant the port selected by `rr`.
  - Increment `conflict_cnt`; it saturates at 16'hFFFF.
- **On every grant**:
  - Register the winner's addr, we and wdata into `ram_addr`/`ram_we`/`ram_din`.
  - Set `gnt` to the winner.
  - Set `rr` to the loser, i.e. `~winner`.
  - Go to ISSUE.
- **ISSUE**: the RAM samples the registered signals on the next edge. At that edge: `ram_we`<=0, go to CAPT.
- **CAPT**: at the next edge:
  - Winner's `rdata` <= `ram_dout`, loaded for both reads and writes; a write returns the RAM's read-during-write value.
  - Winner's `ack`<=1 for exactly one cycle; the other port's `ack` stays 0.
  - Go to IDLE.
- The non-granted `rdata` register is unchanged.
- `ram_addr`/`ram_din` hold their value outside ISSUE. Only `ram_we` is cleared.
- No address arithmetic; addresses pass through unchanged, with width AW.

## Timing
- **Reset values**: state=IDLE, `ram_addr`=0, `ram_we`=0, `ram_din`=0, both `rdata`=0, both `ack`=0, `busy`=0, `gnt`=0, `rr`=0 (CPU first), `conflict_cnt`=0.
- **Latency**: request seen high at edge E0 → grant at E0 → RAM access at E1 → ack high from E2 to E3. This is 3 cycles per access.
- **Throughput**:
  - A different port can be granted at E3, giving back-to-back 3-cycle accesses.
  - The same port can be re-granted at E4 at the earliest, because of the ack mask.
- **`ram_we`**: high for exactly one cycle (E0 to E1) per write grant. It is never high outside ISSUE.
- **Request timing**: `req` may rise in any cycle. A request arriving while busy waits and is sampled at the first IDLE edge.
- **Simultaneous requests**: both ports requesting continuously alternate, CPU first after reset (CPU_PRIO=0). With CPU_PRIO=1 and continuous CPU requests, the DMA is granted only on cycles where the CPU's request is masked.
- **Reset mid-operation**: asynchronous return to reset values.
  - In ISSUE: `ram_we` drops immediately; the write may or may not land.
  - In CAPT: no ack is produced.

## Test plan
- **CPU read**: preload RAM[5]=32'hDEADBEEF; `cpu_req`=1, we=0, addr=5 at E0 → `ram_addr`=5 at E0+, `cpu_ack`=1 and `cpu_rdata`=32'hDEADBEEF during E2–E3, `busy`=1 during E0–E2.
- **DMA write then CPU read**: DMA writes 32'h12345678 to addr 3, then CPU reads addr 3 → `ram_we` high one cycle only, CPU read returns 32'h12345678, `dma_ack` pulses once.
- **Contention (CPU_PRIO=0)**: both hold `req` from reset for 4 accesses → grant order CPU, DMA, CPU, DMA, each ack 3 cycles apart, `conflict_cnt` increments as expected.
- **Fixed priority (CPU_PRIO=1)**: both request, CPU re-requests as soon as allowed → CPU wins every tie, and DMA is granted only in the ack-masked slot.
- **Ack mask**: requester drops `req` one edge after `ack` → exactly one ack per request, no duplicate grant.
- **Async reset**: assert `rst` mid-ISSUE of a write → `ram_we`=0 immediately, no ack, all outputs at reset values, next request serviced normally after `rst` falls.
